// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, branch flush, MEM wait, ECALL park.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       memRead_IDEX,
  input  logic [4:0] rd_IDEX,
  input  logic [4:0] rs1_IFID,
  input  logic [4:0] rs2_IFID,
  input  logic       rs1_use_IFID,
  input  logic       rs2_use_IFID,
  input  logic       branch_taken_EX,
  input  logic       memAccess_EXMEM,
  input  logic       dmem_ack,
  input  logic       ECALL_MEMWB,
  input  logic       ecall_done,
  output logic       stall_PC,
  output logic       stall_IFID,
  output logic       stall_IDEX,
  output logic       stall_EXMEM,
  output logic       flush_IFID,
  output logic       flush_IDEX,
  output logic       bubble_MEMWB,
  output logic       halted,
  output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] loaduse_events
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    ECALL_WAIT = 2'd2,
    HALT       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            load_use_s;
  logic            mem_stall_s;
  logic            run_eval_s;
  logic            ecall_en_s;
  logic            freeze_s;
  logic            flush_if_s;
  logic            flush_id_s;
  logic            lu_stall_s;

  // Hazard detection, next-state and control output decode.
  always_comb begin
    load_use_s  = memRead_IDEX && (rd_IDEX != 5'd0) &&
                  ((rs1_use_IFID && (rs1_IFID == rd_IDEX)) ||
                   (rs2_use_IFID && (rs2_IFID == rd_IDEX)));
    mem_stall_s = memAccess_EXMEM && !dmem_ack;
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    run_eval_s  = 1'b0;
    ecall_en_s  = 1'b1;
    freeze_s    = 1'b0;
    flush_if_s  = 1'b0;
    flush_id_s  = 1'b0;
    lu_stall_s  = 1'b0;

    case (state_q)
      RUN: begin
        run_eval_s = 1'b1;
      end
      MEM_WAIT: begin
        if (mem_stall_s) begin
          freeze_s = 1'b1;
          if (cnt_q == TIMEOUT_C) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          run_eval_s = 1'b1;
        end
      end
      ECALL_WAIT: begin
        // The MEMWB bubble has already removed the ECALL, so do not re-trap on it.
        if (ecall_done) begin
          run_eval_s = 1'b1;
          ecall_en_s = 1'b0;
        end else begin
          freeze_s = 1'b1;
        end
      end
      HALT: begin
        freeze_s = 1'b1;
      end
      default: begin
        freeze_s = 1'b1;
        state_d  = RUN;
        cnt_d    = '0;
      end
    endcase

    if (run_eval_s) begin
      state_d = RUN;
      cnt_d   = '0;
      if (ECALL_MEMWB && ecall_en_s) begin
        freeze_s = 1'b1;
        state_d  = ECALL_WAIT;
      end else if (mem_stall_s) begin
        freeze_s = 1'b1;
        state_d  = MEM_WAIT;
        cnt_d    = CW'(1);
      end else if (branch_taken_EX) begin
        // Wrong-path consumer: the flush makes any load-use stall moot.
        flush_if_s = 1'b1;
        flush_id_s = 1'b1;
      end else if (load_use_s) begin
        lu_stall_s = 1'b1;
        flush_id_s = 1'b1;
      end else begin
        flush_if_s = 1'b0;
      end
    end else begin
      cnt_d = cnt_d;
    end
  end

  assign stall_PC        = freeze_s | lu_stall_s;
  assign stall_IFID      = freeze_s | lu_stall_s;
  assign stall_IDEX      = freeze_s;
  assign stall_EXMEM     = freeze_s;
  assign flush_IFID      = flush_if_s;
  assign flush_IDEX      = flush_id_s;
  assign bubble_MEMWB    = freeze_s;
  assign halted          = (state_q == ECALL_WAIT) || (state_q == HALT);
  assign mem_timeout_err = err_q;

  // Sequencer state, MEM wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;
  logic [31:0] loaduse_events_q;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q   <= 32'd0;
      flush_events_q   <= 32'd0;
      loaduse_events_q <= 32'd0;
    end else begin
      if (stall_PC) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_if_s) begin
        flush_events_q <= flush_events_q + 32'd1;
      end
      if (lu_stall_s) begin
        loaduse_events_q <= loaduse_events_q + 32'd1;
      end
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign flush_events   = flush_events_q;
  assign loaduse_events = loaduse_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int TMO = 4;
  localparam logic [6:0] FREEZE = 7'b1111001;
  localparam logic [6:0] BRANCH = 7'b0000110;
  localparam logic [6:0] LDUSE  = 7'b1100010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic memRead_IDEX = 1'b0;
  logic [4:0] rd_IDEX = 5'd0, rs1_IFID = 5'd0, rs2_IFID = 5'd0;
  logic rs1_use_IFID = 1'b0, rs2_use_IFID = 1'b0;
  logic branch_taken_EX = 1'b0, memAccess_EXMEM = 1'b0, dmem_ack = 1'b0;
  logic ECALL_MEMWB = 1'b0, ecall_done = 1'b0;
  logic stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
  logic flush_IFID, flush_IDEX, bubble_MEMWB, halted, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, loaduse_events;
`endif

  int checks = 0;
  int errors = 0;

  // Model: which phase the core is in, how long it has waited, sticky error.
  bit m_memwait, m_ecall, m_halt, m_err;
  int m_waited;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memRead_IDEX(memRead_IDEX), .rd_IDEX(rd_IDEX),
    .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
    .rs1_use_IFID(rs1_use_IFID), .rs2_use_IFID(rs2_use_IFID),
    .branch_taken_EX(branch_taken_EX), .memAccess_EXMEM(memAccess_EXMEM),
    .dmem_ack(dmem_ack), .ECALL_MEMWB(ECALL_MEMWB), .ecall_done(ecall_done),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
    .stall_EXMEM(stall_EXMEM), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .bubble_MEMWB(bubble_MEMWB), .halted(halted), .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events),
    .loaduse_events(loaduse_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    memRead_IDEX = 1'b0; rd_IDEX = 5'd0; rs1_IFID = 5'd0; rs2_IFID = 5'd0;
    rs1_use_IFID = 1'b0; rs2_use_IFID = 1'b0; branch_taken_EX = 1'b0;
    memAccess_EXMEM = 1'b0; dmem_ack = 1'b0; ECALL_MEMWB = 1'b0; ecall_done = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; checks, then moves the model on.
  task automatic step(input string tag);
    logic [6:0] exp_ctrl, obs_ctrl;
    bit lu, ms, decide, skip_ecall;
    #1;
    if (!rst_n) begin
      m_memwait = 0; m_ecall = 0; m_halt = 0; m_err = 0; m_waited = 0;
    end
    lu = memRead_IDEX && rd_IDEX != 0 &&
         ((rs1_use_IFID && rs1_IFID == rd_IDEX) || (rs2_use_IFID && rs2_IFID == rd_IDEX));
    ms = memAccess_EXMEM && !dmem_ack;
    exp_ctrl = 7'b0000000;
    decide = 0;
    skip_ecall = 0;

    checks++;
    assert (halted === (m_ecall || m_halt)) else begin
      errors++; $error("FAIL %s halted obs=%b exp=%b", tag, halted, m_ecall || m_halt);
    end
    checks++;
    assert (mem_timeout_err === m_err) else begin
      errors++; $error("FAIL %s err obs=%b exp=%b", tag, mem_timeout_err, m_err);
    end

    if (m_halt) exp_ctrl = FREEZE;
    else if (m_ecall) begin
      if (ecall_done) begin decide = 1; skip_ecall = 1; end
      else exp_ctrl = FREEZE;
    end else if (m_memwait) begin
      if (ms) begin
        exp_ctrl = FREEZE;
        if (m_waited + 1 >= TMO) begin m_err = 1; m_halt = 1; m_memwait = 0; end
        else m_waited++;
      end else decide = 1;
    end else decide = 1;

    if (decide) begin
      m_memwait = 0; m_ecall = 0; m_waited = 0;
      if (ECALL_MEMWB && !skip_ecall) begin exp_ctrl = FREEZE; m_ecall = 1; end
      else if (ms) begin exp_ctrl = FREEZE; m_memwait = 1; end
      else if (branch_taken_EX) exp_ctrl = BRANCH;
      else if (lu) exp_ctrl = LDUSE;
    end

    obs_ctrl = {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, bubble_MEMWB};
    checks++;
    assert (obs_ctrl === exp_ctrl) else begin
      errors++; $error("FAIL %s ctrl obs=%b exp=%b", tag, obs_ctrl, exp_ctrl);
    end
    if (!rst_n) begin
      m_memwait = 0; m_ecall = 0; m_halt = 0; m_err = 0; m_waited = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    step("reset");
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert ({stall_cycles, flush_events, loaduse_events} === 96'd0) else begin
      errors++; $error("FAIL perf_reset obs=%h exp=0", {stall_cycles, flush_events, loaduse_events});
    end
`endif
    rst_n = 1'b1;
    step("idle");

    // Load-use for exactly one cycle, then the bubble resolves.
    memRead_IDEX = 1'b1; rd_IDEX = 5'd5; rs1_IFID = 5'd5; rs1_use_IFID = 1'b1;
    step("loaduse");
    memRead_IDEX = 1'b0;
    step("loaduse_resolved");
    memRead_IDEX = 1'b1; rd_IDEX = 5'd0; rs1_IFID = 5'd0;
    step("loaduse_x0");
    rd_IDEX = 5'd7; rs1_IFID = 5'd1; rs2_IFID = 5'd7; rs2_use_IFID = 1'b1;
    step("loaduse_rs2");
    branch_taken_EX = 1'b1;
    step("branch_beats_lu");
    clear_inputs();

    // Memory wait: three un-acked cycles then ack.
    memAccess_EXMEM = 1'b1;
    repeat (3) step("memwait");
    dmem_ack = 1'b1; branch_taken_EX = 1'b1;
    step("mem_ack_branch");
    clear_inputs();
    step("after_ack");
    dmem_ack = 1'b1;
    step("ack_without_access");

    // Timeout: ack never arrives, then error and halt stick.
    clear_inputs();
    memAccess_EXMEM = 1'b1;
    repeat (TMO + 1) step("to_wait");
    clear_inputs();
    repeat (3) step("halt_sticky");
    rst_n = 1'b0;
    step("reset_after_halt");
    rst_n = 1'b1;
    step("run_after_reset");

    // ECALL park and release without re-trapping.
    ecall_done = 1'b1;
    step("done_outside_ecall");
    ecall_done = 1'b0; ECALL_MEMWB = 1'b1;
    step("ecall_enter");
    step("ecall_parked");
    ecall_done = 1'b1;
    step("ecall_release");
    clear_inputs();
    step("ecall_exited");

    // Asynchronous reset in the middle of a memory wait.
    memAccess_EXMEM = 1'b1;
    repeat (2) step("pre_reset_wait");
    rst_n = 1'b0;
    step("reset_mid_wait");
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert ({stall_cycles, flush_events, loaduse_events} === 96'd0) else begin
      errors++; $error("FAIL perf_midreset obs=%h exp=0", {stall_cycles, flush_events, loaduse_events});
    end
`endif
    rst_n = 1'b1;
    clear_inputs();
    step("post_reset");

    // Randomized traffic with periodic resets to escape HALT.
    for (int i = 0; i < 400; i++) begin
      rst_n           = (i % 50 == 49) ? 1'b0 : 1'b1;
      memRead_IDEX    = 1'($urandom_range(0, 1));
      rd_IDEX         = 5'($urandom_range(0, 3));
      rs1_IFID        = 5'($urandom_range(0, 3));
      rs2_IFID        = 5'($urandom_range(0, 3));
      rs1_use_IFID    = 1'($urandom_range(0, 1));
      rs2_use_IFID    = 1'($urandom_range(0, 1));
      branch_taken_EX = ($urandom_range(0, 3) == 0);
      memAccess_EXMEM = ($urandom_range(0, 2) == 0);
      dmem_ack        = 1'($urandom_range(0, 1));
      ECALL_MEMWB     = ($urandom_range(0, 7) == 0);
      ecall_done      = ($urandom_range(0, 2) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
